keypad_scan_4x4: RTL and testbench
==================================

// Module: keypad_scan_4x4
// PURPOSE
//  Physical-side driver for the 4x4 matrix keypad. It is the transmitter that feeds
//  the keypad decoder's keypad_row/keypad_col inputs.
//  Drives one row low at a time, synchronises and debounces the column returns, and
//  presents the pressed key as the active-low one-hot row/col code pair the decoder expects.
//  Sits between the top-level keypad pins and the parameter-entry keypad decoder.
// PARAMETERS
//  SCAN_DIV      1000  clocks per row slot; columns are sampled on the last clock of each slot (>=4)
//  DEBOUNCE_CNT  4     consecutive matching samples required for press and for release (>=1)
//  PULSE_CODES   1     1: codes valid for exactly one clk per press; 0: codes held while key is down
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  col_in      in   4  raw column pins, pulled up, active-low, asynchronous
//  row_drive   out  4  row pins, active-low one-hot (row0=4'b1110 ... row3=4'b0111)
//  keypad_row  out  4  debounced row code, active-low one-hot; 4'b1111 when no key
//  keypad_col  out  4  debounced col code, active-low one-hot; 4'b1111 when no key
//  key_press   out  1  one-clk pulse on an accepted press, aligned with the first valid code cycle
//  key_held    out  1  high from press acceptance until release acceptance
// BEHAVIOUR
//  Reset (clk edge with reset=1): state SCAN, row index 0, row_drive=4'b1110,
//   keypad_row=keypad_col=4'b1111, key_press=0, key_held=0, all counters 0, sync flops 4'b1111.
//  col_in passes through a 2-FF synchroniser; col_s is the second-stage output.
//  Slot counter runs 0..SCAN_DIV-1 and wraps. Sample point is slot counter==SCAN_DIV-1.
//  States:
//   SCAN
//    - At each sample point: if col_s has exactly one bit low, latch candidate (row, col_s),
//      set match count=1, and hold row_drive on that row.
//      Then go to DEBOUNCE, or go straight to HELD when DEBOUNCE_CNT==1.
//    - If col_s==4'b1111 or two or more bits are low (multi-key): ignore, and advance the
//      row index (3 wraps to 0). The new row_drive takes effect on the next clk.
//   DEBOUNCE
//    - Row frozen.
//    - Each sample: col_s==candidate -> count+1. On reaching DEBOUNCE_CNT, go to HELD.
//    - Any mismatch -> back to SCAN with the row index advanced; no outputs change.
//   HELD
//    - Entry clk: key_press=1 for one clk, key_held=1, keypad_row/col=candidate.
//    - PULSE_CODES=1: codes return to 4'b1111 on the following clk.
//    - PULSE_CODES=0: codes stay until release.
//    - Each sample: col_s==4'b1111 -> release count+1; any other value clears the release count.
//    - On DEBOUNCE_CNT consecutive idle samples: key_held=0, codes=4'b1111, and go to SCAN
//      with the row index advanced.
//  Latency: press output is 1 clk after the sample point of the DEBOUNCE_CNT-th consecutive match.
//  No auto-repeat: a held key produces exactly one key_press.
//  Second key pressed while in HELD: ignored; only the latched key's release is tracked.
//  Reset mid-press: everything returns to reset values. A key still down is re-detected
//   from SCAN and produces a new press.
//  Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CNT+1); no overflow is possible.
// TESTING  (bench: SCAN_DIV=4, DEBOUNCE_CNT=3; keypad model pulls col c low while row_drive[r]==0)
//  1. Reset, no key -> row_drive cycles 1110,1101,1011,0111,1110 every 4 clks;
//     codes 4'b1111; key_press never asserts.
//  2. Hold key '5' (row1,col1) -> exactly one key_press; keypad_row=4'b1101 and
//     keypad_col=4'b1101 for 1 clk; key_held=1 until release, then 0 after 3 idle samples.
//  3. Key 'D' (row3,col1) bounces for 1 sample after first detection -> no press;
//     scan resumes at row0; a stable press is later accepted with codes 0111/1101.
//  4. PULSE_CODES=0, key 'A' (row0,col3) -> codes 1110/0111 held for the entire press;
//     back to 1111 in the same clk key_held falls.
//  5. Keys '1' and '3' pressed together (row0, col_s=4'b1010) -> no press while both are held;
//     releasing '3' -> press of '1' (1110/1110).
//  6. reset asserted 1 clk after key_press for '7' -> next clk all outputs at reset values;
//     with the key still held, a second key_press arrives after a full debounce.

Source files
------------

// File: rtl/keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_4x4
// Description : Row-scanning driver for a 4x4 matrix keypad. It drives one row
//               low at a time and synchronises the column returns. It then
//               debounces both press and release, and presents the accepted
//               key as an active-low one-hot row/col code pair.
// Ports       : clk         - system clock
//               reset       - synchronous, active-high reset
//               col_in      - raw column pins (pulled up, active-low, async)
//               row_drive   - row pins, active-low one-hot
//               keypad_row  - debounced row code, 4'b1111 when no key
//               keypad_col  - debounced col code, 4'b1111 when no key
//               key_press   - one-clk pulse on an accepted press
//               key_held    - high from press acceptance to release acceptance
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_4x4 #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int PULSE_CODES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_drive,
    output logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic       key_press,
    output logic       key_held
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  C_CNT_DONE  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]        C_IDLE      = 4'b1111;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_col_meta;
    logic [3:0]          r_col_s;
    logic [SLOT_W-1:0]   r_slot;
    logic [1:0]          r_row_idx;
    logic [3:0]          r_cand_row;
    logic [3:0]          r_cand_col;
    logic [CNT_W-1:0]    r_count;

    logic                w_sample;
    logic                w_one_low;
    logic [1:0]          w_next_idx;
    logic [3:0]          w_next_row_drive;
    logic [CNT_W-1:0]    w_count_inc;

    // Two-stage synchroniser for the asynchronous column pins. It idles high
    // so that reset never looks like a pressed key.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_meta <= C_IDLE;
            r_col_s    <= C_IDLE;
        end else begin
            r_col_meta <= col_in;
            r_col_s    <= r_col_meta;
        end
    end

    // Row slot timer. It runs continuously. Sampling on the last clock of a
    // slot leaves at least two clocks for a new row drive to clear the
    // synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot <= '0;
        end else if (r_slot == C_SLOT_LAST) begin
            r_slot <= '0;
        end else begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    assign w_sample         = (r_slot == C_SLOT_LAST);
    assign w_next_idx       = r_row_idx + 2'd1;
    assign w_next_row_drive = ~(4'b0001 << w_next_idx);
    assign w_count_inc      = r_count + C_CNT_ONE;

    // Only a single low column is a valid candidate. Multi-key patterns on one
    // row are ambiguous and are skipped.
    always_comb begin
        w_one_low = 1'b0;
        case (r_col_s)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_one_low = 1'b1;
            default:                            w_one_low = 1'b0;
        endcase
    end

    // Scan / debounce / held controller. r_count is the match count in
    // DEBOUNCE and the idle-sample count in HELD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= 2'd0;
            row_drive  <= 4'b1110;
            r_cand_row <= C_IDLE;
            r_cand_col <= C_IDLE;
            r_count    <= '0;
            keypad_row <= C_IDLE;
            keypad_col <= C_IDLE;
            key_press  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            key_press <= 1'b0;
            // In pulse mode the codes last only for the acceptance clock.
            if (PULSE_CODES != 0) begin
                keypad_row <= C_IDLE;
                keypad_col <= C_IDLE;
            end

            if (w_sample) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_one_low) begin
                            // Row drive stays where it is while debouncing.
                            r_cand_row <= row_drive;
                            r_cand_col <= r_col_s;
                            if (DEBOUNCE_CNT == 1) begin
                                r_state    <= ST_HELD;
                                r_count    <= '0;
                                key_press  <= 1'b1;
                                key_held   <= 1'b1;
                                keypad_row <= row_drive;
                                keypad_col <= r_col_s;
                            end else begin
                                r_state <= ST_DEBOUNCE;
                                r_count <= C_CNT_ONE;
                            end
                        end else begin
                            r_row_idx <= w_next_idx;
                            row_drive <= w_next_row_drive;
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (r_col_s == r_cand_col) begin
                            if (w_count_inc == C_CNT_DONE) begin
                                r_state    <= ST_HELD;
                                r_count    <= '0;
                                key_press  <= 1'b1;
                                key_held   <= 1'b1;
                                keypad_row <= r_cand_row;
                                keypad_col <= r_cand_col;
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end else begin
                            r_state   <= ST_SCAN;
                            r_count   <= '0;
                            r_row_idx <= w_next_idx;
                            row_drive <= w_next_row_drive;
                        end
                    end

                    ST_HELD: begin
                        // Any non-idle value, including a second key on the
                        // same row, restarts the release count.
                        if (r_col_s == C_IDLE) begin
                            if (w_count_inc == C_CNT_DONE) begin
                                r_state    <= ST_SCAN;
                                r_count    <= '0;
                                key_held   <= 1'b0;
                                keypad_row <= C_IDLE;
                                keypad_col <= C_IDLE;
                                r_row_idx  <= w_next_idx;
                                row_drive  <= w_next_row_drive;
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end else begin
                            r_count <= '0;
                        end
                    end

                    default: begin
                        r_state <= ST_SCAN;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_4x4
// Description : Directed self-checking bench for keypad_scan_4x4. Instance A
//               runs with pulsed codes and instance B with held codes. Each
//               instance has its own keypad matrix model driven from a shared
//               key map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_4x4;

    logic        clk;
    logic        reset;
    logic [15:0] keys;          // bit r*4+c = key at row r, col c is down
    logic [3:0]  col_a, col_b;
    logic [3:0]  row_a, row_b;
    logic [3:0]  krow_a, kcol_a, krow_b, kcol_b;
    logic        press_a, press_b, held_a, held_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;             // edges since the last reset edge
    int pcnt_a = 0;
    int pcnt_b = 0;

    keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .PULSE_CODES(1)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .col_in     (col_a),
        .row_drive  (row_a),
        .keypad_row (krow_a),
        .keypad_col (kcol_a),
        .key_press  (press_a),
        .key_held   (held_a)
    );

    keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .PULSE_CODES(0)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .col_in     (col_b),
        .row_drive  (row_b),
        .keypad_row (krow_b),
        .keypad_col (kcol_b),
        .key_press  (press_b),
        .key_held   (held_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_a = 4'b1111;
        col_b = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_a[r]) col_a[c] = 1'b0;
                if (keys[r*4+c] && !row_b[r]) col_b[c] = 1'b0;
            end
        end
    end

    // Count key_press pulses shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (press_a) pcnt_a++;
        if (press_b) pcnt_b++;
    end

    // Called at a negedge. Leaves the bench at the negedge after the reset edge (cyc=0).
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic adv_to(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (row_a !== 4'b1110) begin errors++; $display("FAIL reset_row_a got %b exp 1110", row_a); end
        checks++; if ({krow_a, kcol_a} !== 8'hFF) begin errors++; $display("FAIL reset_codes_a got %b/%b exp 1111/1111", krow_a, kcol_a); end
        checks++; if ({press_a, held_a} !== 2'b00) begin errors++; $display("FAIL reset_flags_a got %b%b exp 00", press_a, held_a); end
        checks++; if ({row_b, krow_b, kcol_b} !== 12'hEFF) begin errors++; $display("FAIL reset_b got %b %b %b exp 1110 1111 1111", row_b, krow_b, kcol_b); end
        checks++; if ({press_b, held_b} !== 2'b00) begin errors++; $display("FAIL reset_flags_b got %b%b exp 00", press_b, held_b); end
    endtask

    task automatic test_scan_idle();
        logic [3:0] exp;
        logic [1:0] idx;
        keys = '0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            adv_to(k);
            idx = 2'((k / 4) % 4);
            exp = ~(4'b0001 << idx);
            checks++; if (row_a !== exp) begin errors++; $display("FAIL scan_row k=%0d got %b exp %b", k, row_a, exp); end
            checks++; if ({krow_a, kcol_a, press_a} !== 9'h1FF << 1) begin errors++; $display("FAIL scan_idle_out k=%0d got %b/%b press=%b exp 1111/1111 press=0", k, krow_a, kcol_a, press_a); end
        end
    endtask

    task automatic test_press_5();
        int p0;
        keys = '0;
        do_reset();
        p0 = pcnt_a;
        keys[1*4+1] = 1'b1;
        adv_to(15);
        checks++; if (press_a !== 1'b0) begin errors++; $display("FAIL k5_early_press got %b exp 0", press_a); end
        adv_to(16);
        checks++; if (press_a !== 1'b1) begin errors++; $display("FAIL k5_press got %b exp 1", press_a); end
        checks++; if ({krow_a, kcol_a} !== 8'b1101_1101) begin errors++; $display("FAIL k5_codes got %b/%b exp 1101/1101", krow_a, kcol_a); end
        checks++; if (held_a !== 1'b1) begin errors++; $display("FAIL k5_held got %b exp 1", held_a); end
        adv_to(17);
        checks++; if ({press_a, krow_a, kcol_a} !== 9'b0_1111_1111) begin errors++; $display("FAIL k5_pulse_end got %b %b/%b exp 0 1111/1111", press_a, krow_a, kcol_a); end
        checks++; if (row_a !== 4'b1101) begin errors++; $display("FAIL k5_row_frozen got %b exp 1101", row_a); end
        adv_to(40);
        checks++; if (pcnt_a - p0 !== 1) begin errors++; $display("FAIL k5_no_repeat got %0d presses exp 1", pcnt_a - p0); end
        keys = '0;
        adv_to(51);
        checks++; if (held_a !== 1'b1) begin errors++; $display("FAIL k5_held_before_release got %b exp 1", held_a); end
        adv_to(52);
        checks++; if ({held_a, row_a} !== 5'b0_1011) begin errors++; $display("FAIL k5_release got held=%b row=%b exp held=0 row=1011", held_a, row_a); end
    endtask

    task automatic test_bounce_d();
        int p0;
        keys = '0;
        do_reset();
        p0 = pcnt_a;
        keys[3*4+1] = 1'b1;
        adv_to(16);
        keys = '0;               // bounce open for one sample
        adv_to(19);
        checks++; if (row_a !== 4'b0111) begin errors++; $display("FAIL kd_row_frozen got %b exp 0111", row_a); end
        adv_to(20);
        checks++; if (row_a !== 4'b1110) begin errors++; $display("FAIL kd_rescan_row got %b exp 1110", row_a); end
        checks++; if ({held_a, krow_a, kcol_a} !== 9'b0_1111_1111 || pcnt_a != p0) begin errors++; $display("FAIL kd_no_press got held=%b codes=%b/%b presses=%0d exp 0 1111/1111 0", held_a, krow_a, kcol_a, pcnt_a - p0); end
        keys[3*4+1] = 1'b1;
        adv_to(43);
        checks++; if (pcnt_a - p0 !== 0) begin errors++; $display("FAIL kd_early got %0d presses exp 0", pcnt_a - p0); end
        adv_to(44);
        checks++; if ({press_a, krow_a, kcol_a} !== 9'b1_0111_1101) begin errors++; $display("FAIL kd_press got %b %b/%b exp 1 0111/1101", press_a, krow_a, kcol_a); end
        keys = '0;
        adv_to(60);
        checks++; if (held_a !== 1'b0) begin errors++; $display("FAIL kd_release got %b exp 0", held_a); end
    endtask

    task automatic test_hold_codes();
        keys = '0;
        do_reset();
        keys[0*4+3] = 1'b1;
        adv_to(12);
        checks++; if ({press_b, held_b, krow_b, kcol_b} !== 10'b11_1110_0111) begin errors++; $display("FAIL ka_press got %b%b %b/%b exp 11 1110/0111", press_b, held_b, krow_b, kcol_b); end
        adv_to(30);
        checks++; if ({press_b, held_b, krow_b, kcol_b} !== 10'b01_1110_0111) begin errors++; $display("FAIL ka_codes_held got %b%b %b/%b exp 01 1110/0111", press_b, held_b, krow_b, kcol_b); end
        adv_to(32);
        keys = '0;
        adv_to(43);
        checks++; if ({held_b, krow_b, kcol_b} !== 9'b1_1110_0111) begin errors++; $display("FAIL ka_before_release got %b %b/%b exp 1 1110/0111", held_b, krow_b, kcol_b); end
        adv_to(44);
        checks++; if ({held_b, krow_b, kcol_b} !== 9'b0_1111_1111) begin errors++; $display("FAIL ka_release got %b %b/%b exp 0 1111/1111", held_b, krow_b, kcol_b); end
    endtask

    task automatic test_multi_key();
        int p0;
        keys = '0;
        do_reset();
        p0 = pcnt_a;
        keys[0] = 1'b1;          // '1'
        keys[2] = 1'b1;          // '3'
        adv_to(24);
        checks++; if (pcnt_a - p0 !== 0 || held_a !== 1'b0) begin errors++; $display("FAIL mk_ignored got presses=%0d held=%b exp 0 0", pcnt_a - p0, held_a); end
        checks++; if (row_a !== 4'b1011) begin errors++; $display("FAIL mk_scan_row got %b exp 1011", row_a); end
        keys[2] = 1'b0;
        adv_to(43);
        checks++; if (press_a !== 1'b0) begin errors++; $display("FAIL mk_early got %b exp 0", press_a); end
        adv_to(44);
        checks++; if ({press_a, krow_a, kcol_a} !== 9'b1_1110_1110) begin errors++; $display("FAIL mk_press got %b %b/%b exp 1 1110/1110", press_a, krow_a, kcol_a); end
        keys = '0;
        adv_to(60);
        checks++; if (held_a !== 1'b0) begin errors++; $display("FAIL mk_release got %b exp 0", held_a); end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        keys = '0;
        do_reset();
        keys[2*4+0] = 1'b1;      // '7'
        adv_to(20);
        checks++; if ({press_a, krow_a, kcol_a} !== 9'b1_1011_1110) begin errors++; $display("FAIL k7_press got %b %b/%b exp 1 1011/1110", press_a, krow_a, kcol_a); end
        do_reset();
        checks++; if ({row_a, krow_a, kcol_a, press_a, held_a} !== 14'b1110_1111_1111_00) begin errors++; $display("FAIL k7_reset got %b %b %b %b %b exp 1110 1111 1111 0 0", row_a, krow_a, kcol_a, press_a, held_a); end
        p0 = pcnt_a;
        adv_to(19);
        checks++; if (press_a !== 1'b0) begin errors++; $display("FAIL k7_early got %b exp 0", press_a); end
        adv_to(20);
        checks++; if ({press_a, krow_a, kcol_a} !== 9'b1_1011_1110 || pcnt_a - p0 != 1) begin errors++; $display("FAIL k7_repress got %b %b/%b presses=%0d exp 1 1011/1110 1", press_a, krow_a, kcol_a, pcnt_a - p0); end
        keys = '0;
        adv_to(36);
        checks++; if (held_a !== 1'b0) begin errors++; $display("FAIL k7_release got %b exp 0", held_a); end
    endtask

    initial begin
        reset = 1'b1;
        keys  = '0;
        test_reset();
        test_scan_idle();
        test_press_5();
        test_bounce_d();
        test_hold_codes();
        test_multi_key();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
